// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the memory port arbiter:
//   - arb_state_t : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   - REQ_*       : requester index assignments (loader, data LD/ST, fetch)
//   - *_DEFAULT   : default requester count, address and data widths
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int REQ_LOADER   = 0;
    localparam int REQ_DATA     = 1;
    localparam int REQ_FETCH    = 2;

    localparam int NREQ_DEFAULT = 3;
    localparam int AW_DEFAULT   = 16;
    localparam int DW_DEFAULT   = 32;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_rr_pick
// Combinational rotate-priority picker. Searches req starting at index ptr,
// then ptr+1, ... wrapping modulo NREQ, and reports the first asserted index.
// Ports:
//   req     in  NREQ  request vector
//   ptr     in  PW    index with highest priority this round (< NREQ)
//   winner  out PW    first asserted index at or after ptr (0 if none)
//   any_req out 1     at least one request bit is set
// ---------------------------------------------------------------------------
module mem_port_arbiter_rr_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   winner,
    output logic            any_req
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest asserted index
    // (smallest rotation from ptr) is the last assignment and wins.
    always_comb begin
        winner  = '0;
        any_req = |req;
        idx     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[idx]) begin
                winner = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory among NREQ requesters (0 loader, 1 data
// LD/ST, 2 fetch). One transaction at a time, round-robin grant, fixed read
// latency MEM_LAT (>= 1) from mem_en to valid mem_rdata.
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   req         per-requester request level (sampled only in IDLE)
//   req_we      per-requester write enable (1 = write)
//   req_addr    requester i address at [i*AW +: AW]
//   req_wdata   requester i write data at [i*DW +: DW]
//   gnt         one-cycle pulse to the owner when the access is issued
//   done        one-cycle pulse to the owner when the access completes
//   rdata       read result, meaningful while done is high for a read
//   mem_en      memory strobe (high for the single ISSUE cycle)
//   mem_we      memory write enable (qualifies mem_en)
//   mem_addr    memory address, holds last latched value
//   mem_wdata   memory write data, holds last latched value
//   mem_rdata   memory read data
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NREQ    = NREQ_DEFAULT,
    parameter int AW      = AW_DEFAULT,
    parameter int DW      = DW_DEFAULT,
    parameter int MEM_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MEM_LAT + 1);

    arb_state_t    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] winner;
    logic [PW-1:0] ptr_next;
    logic          any_req;
    logic          we_q;
    logic [CW-1:0] cnt;

    mem_port_arbiter_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign ptr_next = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);

    // Outputs are registered: they are loaded on the transition into the
    // state in which they must be visible, and cleared by default otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            we_q      <= 1'b0;
            cnt       <= '0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            gnt       <= '0;
            done      <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
        end else begin
            gnt    <= '0;
            done   <= '0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner       <= winner;
                        we_q        <= req_we[winner];
                        mem_addr    <= req_addr[int'(winner)*AW +: AW];
                        mem_wdata   <= req_wdata[int'(winner)*DW +: DW];
                        mem_en      <= 1'b1;
                        mem_we      <= req_we[winner];
                        gnt[winner] <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    ptr <= ptr_next;
                    if (we_q) begin
                        // Writes complete in the memory on the strobe cycle.
                        done[owner] <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt   <= CW'(MEM_LAT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // mem_rdata is valid MEM_LAT cycles after mem_en, which
                    // is the WAIT cycle where the count has run down to 1.
                    if (cnt == CW'(1)) begin
                        rdata       <= mem_rdata;
                        done[owner] <= 1'b1;
                        cnt         <= '0;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Multi-cycle arbiter that shares the processor's single-port data/instruction memory among up to NREQ requesters: loader/debug port, the control unit's LD/ST path, and instruction fetch. It serialises one memory transaction at a time using a round-robin grant and a fixed memory read latency. It returns read data and a completion pulse to the owning requester. It sits between the multi-cycle control unit/datapath and the memory macro.

## Interface
- NREQ, 3: number of requesters. Index 0 is loader, 1 is data (LD/ST), 2 is fetch.
- AW, 16: address width.
- DW, 32: data width.
- MEM_LAT, 2: cycles from mem_en to valid mem_rdata. Legal range is ≥1.
- clk  in  1  clock. One clock domain.
- rst  in  1  reset; synchronous, active-high.
- req  in  NREQ  per-requester request level.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  requester i's address at [i*AW +: AW].
- req_wdata  in  NREQ*DW  requester i's write data at [i*DW +: DW].
- gnt  out  NREQ  one-cycle pulse: request accepted and issued.
- done  out  NREQ  one-cycle pulse: transaction complete.
- rdata  out  DW  read result. Valid only while done is high for a read.
- mem_en, mem_we  out  1  memory strobe and write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.

## Operation
- States:
  - IDLE: arbitrate among asserted req bits; if none, stay in IDLE.
  - ISSUE: drive the memory and pulse gnt.
  - WAIT: read only; down-counter from MEM_LAT.
  - RESP: pulse done.
- IDLE to ISSUE when any req bit is 1:
  - Winner is the first asserted index searching ptr, ptr+1, … modulo NREQ.
  - Latch owner, we, addr and wdata from the winner's slice.
- ISSUE:
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latched values.
  - gnt[owner]=1.
  - ptr <= (owner+1) mod NREQ.
  - Next state is WAIT for a read, RESP for a write.
- WAIT:
  - Counter is loaded with MEM_LAT at ISSUE and decrements each WAIT cycle.
  - On the cycle the count reaches 1, rdata register <= mem_rdata and the next state is RESP.
- RESP:
  - done[owner]=1.
  - Next state is always IDLE.
- Requester rules:
  - req_we, req_addr and req_wdata must stay stable from req rising until gnt.
  - req may drop after gnt.
  - req still high at the next IDLE counts as a new transaction.
- req is sampled only in IDLE. A req that rises and falls outside IDLE is never seen and is never granted.
- Only one transaction is in flight at a time. No write buffering; no read/write reordering.
- Outputs outside their active state are 0: gnt, done, mem_en, mem_we.
- mem_addr and mem_wdata hold their last latched value.

## Timing
- Reset, at the next clk edge with rst=1:
  - state=IDLE, ptr=0, owner=0, counter=0.
  - rdata=0, mem_addr=0, mem_wdata=0.
  - gnt, done, mem_en and mem_we are all 0.
- Reset mid-transaction aborts it:
  - No gnt or done is issued afterwards; mem_en drops from the next cycle.
  - An in-flight read result is discarded.
- Read accepted in IDLE at cycle c:
  - ISSUE and gnt at c+1.
  - mem_rdata sampled at c+1+MEM_LAT.
  - done with rdata at c+2+MEM_LAT.
  - Back in IDLE at c+3+MEM_LAT.
- Write accepted at cycle c: ISSUE at c+1, done at c+2, IDLE at c+3.
- Minimum spacing between grants is MEM_LAT+3 cycles (reads) or 3 cycles (writes).
- Simultaneous requests: exactly one grant per transaction. Losers remain pending.
- Fairness: a continuously asserted requester waits at most NREQ-1 transactions.
- ptr wraps from NREQ-1 to 0.
- MEM_LAT=1 boundary: exactly one WAIT cycle.
- Counter width is $clog2(MEM_LAT+1).

## Structure
- Shared package contents:
  - State enum: IDLE, ISSUE, WAIT, RESP.
  - Requester index constants: REQ_LOADER=0, REQ_DATA=1, REQ_FETCH=2.
  - Defaults for AW and DW.
- One sub-module, rr_pick: a combinational rotate-priority picker.
  - Inputs: req vector and ptr.
  - Outputs: winner index and any_req.
- The FSM, latches, counter and ptr stay in mem_port_arbiter.

## Test plan
1. Reset and idle: assert rst for 2 cycles with random req → all outputs 0, no mem_en. Release with req=0 → remains idle, no gnt.
2. Single read, MEM_LAT=2: req[1] with addr 0x0010; memory model returns ~addr two cycles after mem_en → gnt[1] one cycle after sampling, done[1] 4 cycles after sampling with rdata=0xFFFFFFEF.
3. Round-robin: req=3'b111 held continuously → grant order 0,1,2,0,1. With req=3'b101 held → order 0,2,0.
4. Write then read to the same address: req[0] writes 0xDEADBEEF to 0x0040, then req[2] reads 0x0040 → mem_we for exactly one cycle, done[0] 2 cycles after sampling, then done[2] with rdata=0xDEADBEEF.
5. Reset mid-read: assert rst during WAIT → no done is issued, ptr=0. The next req=3'b110 grants index 1 first.
6. MEM_LAT=1 build: a read completes with done 3 cycles after sampling, and rdata matches the model.
